// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle Y86-style control FSM stepping one instruction through its stages.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, start_pc            begin execution at start_pc (honoured only in IDLE/HALT)
//   icode, ifun                decoded fetch fields (combinational from the datapath)
//   instr_valid, imem_error    fetch status
//   dmem_error, mem_ready      data-memory status / access complete
//   cnd                        branch condition from execute
//   valC, valP, valM           PC-update candidates
//   pc                         current fetch PC
//   f_en..w_en                 one-hot stage enables
//   stat                       1=AOK 2=HLT 3=ADR 4=INS
//   busy, halted, instr_count  run status and retired-instruction count
module stage_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] start_pc,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        mem_ready,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] pc,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        halted,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT} state_t;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  state_t state, nxt;
  logic [2:0] nstat;
  logic mem_acc, fetch_bad, unused_ifun;
  assign unused_ifun = ^ifun;
  // only loads, stores, call, ret, push and pop wait on data memory
  assign mem_acc = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign fetch_bad = imem_error || !instr_valid || icode == 4'h0;
  always_comb begin
    nxt = state;
    nstat = stat;
    case (state)
      IDLE, HALT: begin
        nxt = start ? FETCH : state;
        nstat = start ? AOK : stat;
      end
      FETCH: begin
        nxt = fetch_bad ? HALT : DECODE;
        nstat = imem_error ? ADR : !instr_valid ? INS : icode == 4'h0 ? HLT : stat;
      end
      DECODE:    nxt = EXECUTE;
      EXECUTE:   nxt = MEMORY;
      MEMORY: begin
        nxt = !mem_acc ? WRITEBACK : !mem_ready ? MEMORY : dmem_error ? HALT : WRITEBACK;
        nstat = (mem_acc && mem_ready && dmem_error) ? ADR : stat;
      end
      WRITEBACK: nxt = PCUPD;
      PCUPD:     nxt = FETCH;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      stat <= AOK;
      instr_count <= '0;
      {f_en, d_en, e_en, m_en, w_en} <= '0;
      busy <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= nxt;
      stat <= nstat;
      f_en <= nxt == FETCH;
      d_en <= nxt == DECODE;
      e_en <= nxt == EXECUTE;
      m_en <= nxt == MEMORY;
      w_en <= nxt == WRITEBACK;
      busy <= !(nxt inside {IDLE, HALT});
      halted <= nxt == HALT;
      if ((state == IDLE || state == HALT) && start) pc <= start_pc;
      if (state == PCUPD) begin
        pc <= (icode == 4'h8 || (icode == 4'h7 && cnd)) ? valC : icode == 4'h9 ? valM : valP;
        instr_count <= instr_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: randomized scoreboard bench for stage_sequencer against a per-instruction cycle model.
module tb_stage_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0] start_pc = '0;
  logic [3:0] icode = '0, ifun = '0;
  logic instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0, mem_ready = 1'b0, cnd = 1'b0;
  logic [63:0] valC = '0, valP = '0, valM = '0;
  logic [63:0] pc;
  logic f_en, d_en, e_en, m_en, w_en, busy, halted;
  logic [2:0] stat;
  logic [31:0] instr_count;

  stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .icode(icode), .ifun(ifun), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .mem_ready(mem_ready), .cnd(cnd),
    .valC(valC), .valP(valP), .valM(valM), .pc(pc),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .stat(stat), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] EF = 5'b10000, ED = 5'b01000, EE = 5'b00100, EM = 5'b00010, EW = 5'b00001, EN = 5'b00000;

  typedef struct packed {
    logic [4:0]  en;
    logic        busy;
    logic        halted;
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  logic [2:0] m_stat = 3'd1;

  function automatic obs_t now();
    return '{en: {f_en, d_en, e_en, m_en, w_en}, busy: busy, halted: halted, stat: stat, pc: pc, cnt: instr_count};
  endfunction

  function automatic obs_t mk(input logic [4:0] en, input logic b, input logic h, input logic [2:0] st,
                              input logic [63:0] p, input logic [31:0] c);
    return '{en: en, busy: b, halted: h, stat: st, pc: p, cnt: c};
  endfunction

  task automatic chk(input string name, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got en=%b busy=%b halted=%b stat=%0d pc=%h cnt=%0d / want en=%b busy=%b halted=%b stat=%0d pc=%h cnt=%0d",
               name, a.en, a.busy, a.halted, a.stat, a.pc, a.cnt, e.en, e.busy, e.halted, e.stat, e.pc, e.cnt);
    end
  endtask

  // expected observation of one cycle while running (or the first HALT cycle)
  task automatic expect_cyc(input logic [4:0] en, input logic [2:0] st, input logic h);
    exp_q.push_back(mk(en, !h, h, st, m_pc, m_cnt));
  endtask

  // monitor: every running cycle and every HALT entry is an output to be scored
  logic h_prev = 1'b0;
  int n_pop = 0;
  always @(negedge clk) begin
    if (rst_n && (busy || (halted && !h_prev))) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got en=%b pc=%h stat=%0d with nothing expected", now().en, pc, stat);
      end else begin
        chk($sformatf("trace[%0d]", n_pop), now(), exp_q.pop_front());
        n_pop++;
      end
    end
    h_prev = halted;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'($urandom);
    start_pc = {$urandom, $urandom};
  endtask

  task automatic do_start(input logic [63:0] p);
    start = 1'b1;
    start_pc = p;
    m_pc = p;
    m_stat = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; h=1 if it ended in HALT.
  task automatic exec(input logic [3:0] ic, input logic c, input logic iv, input logic ie, input logic de,
                      input int waits, input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                      input logic rst_mem, output logic h);
    logic [2:0] st;
    logic mem;
    icode = ic; ifun = 4'($urandom); cnd = c; instr_valid = iv; imem_error = ie; dmem_error = de;
    valC = vc; valP = vp; valM = vm; mem_ready = 1'($urandom);
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    st = ie ? 3'd3 : !iv ? 3'd4 : ic == 4'h0 ? 3'd2 : 3'd0;
    h = 1'b0;
    expect_cyc(EF, 3'd1, 1'b0);
    if (st != 3'd0) begin
      tick();
      start = 1'b0;
      m_stat = st;
      expect_cyc(EN, st, 1'b1);
      h = 1'b1;
      return;
    end
    tick(); expect_cyc(ED, 3'd1, 1'b0);
    tick(); expect_cyc(EE, 3'd1, 1'b0);
    tick();
    if (rst_mem) begin
      #1 rst_n = 1'b0;
      #1 chk("async_reset_in_memory", now(), mk(EN, 1'b0, 1'b0, 3'd1, 64'd0, 32'd0));
      rst_n = 1'b1;
      start = 1'b0;
      m_pc = '0; m_cnt = '0; m_stat = 3'd1;
      return;
    end
    if (mem) for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      expect_cyc(EM, 3'd1, 1'b0);
      tick();
    end
    mem_ready = mem ? 1'b1 : 1'($urandom);
    if (!mem) dmem_error = 1'($urandom);
    expect_cyc(EM, 3'd1, 1'b0);
    if (mem && de) begin
      tick();
      start = 1'b0;
      m_stat = 3'd3;
      expect_cyc(EN, 3'd3, 1'b1);
      h = 1'b1;
      return;
    end
    tick(); expect_cyc(EW, 3'd1, 1'b0);
    tick(); expect_cyc(EN, 3'd1, 1'b0);
    m_pc = (ic == 4'h8 || (ic == 4'h7 && c)) ? vc : ic == 4'h9 ? vm : vp;
    m_cnt = m_cnt + 32'd1;
    tick();
  endtask

  // HALT must hold pc/stat/count whatever the datapath does
  task automatic hold_halt(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      icode = 4'($urandom); cnd = 1'($urandom); mem_ready = 1'($urandom); dmem_error = 1'($urandom);
      valC = {$urandom, $urandom}; valP = {$urandom, $urandom}; valM = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("halt_hold", now(), mk(EN, 1'b0, 1'b1, m_stat, m_pc, m_cnt));
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    logic [3:0] ic;
    #12;
    chk("reset_state", now(), mk(EN, 1'b0, 1'b0, 3'd1, 64'd0, 32'd0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(64'h20);
    exec(4'h6, 0, 1, 0, 0, 0, 64'h999, 64'h22, 64'h777, 0, h);
    exec(4'h7, 1, 1, 0, 0, 0, 64'h100, 64'h29, 64'h555, 0, h);
    exec(4'h7, 0, 1, 0, 0, 0, 64'h100, 64'h29, 64'h555, 0, h);
    exec(4'h5, 0, 1, 0, 0, 3, 64'h123, 64'h40, 64'h456, 0, h);
    exec(4'h6, 0, 0, 0, 0, 0, 64'h1, 64'h2, 64'h3, 0, h);
    hold_halt(3);
    do_start(64'h0);
    exec(4'hA, 0, 1, 0, 1, 0, 64'h1, 64'h2, 64'h3, 0, h);
    hold_halt(2);
    do_start(64'h80);
    exec(4'h3, 0, 0, 1, 0, 0, 64'h1, 64'h2, 64'h3, 0, h);
    hold_halt(2);
    for (int r = 0; r < 30; r++) begin
      do_start({$urandom, $urandom});
      h = 1'b0;
      for (int k = 0; k < 20 && !h; k++) begin
        ic = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 15) == 0) ic = 4'h0;
        exec(ic, 1'($urandom), $urandom_range(0, 24) != 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 3),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, h);
      end
      if (!h) exec(4'h0, 0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, h);
      hold_halt($urandom_range(1, 3));
    end
    do_start(64'h300);
    exec(4'h5, 0, 1, 0, 0, 5, 64'h1, 64'h2, 64'h3, 1, h);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", now(), mk(EN, 1'b0, 1'b0, 3'd1, 64'd0, 32'd0));
    do_start(64'h20);
    exec(4'h0, 0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, h);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: begin execution at start_pc.
REQ-004 SHALL have port start_pc, input, 64 bits: initial PC, sampled with start.
REQ-005 SHALL have ports icode and ifun, input, 4 bits each: decoded fields from the fetch datapath.
REQ-006 SHALL have ports instr_valid, imem_error and dmem_error, input, 1 bit each: fetch status and data-memory status.
REQ-007 SHALL have port mem_ready, input, 1 bit: data-memory access complete.
REQ-008 SHALL have port cnd, input, 1 bit: branch condition from execute.
REQ-009 SHALL have ports valC, valP and valM, input, 64 bits each: PC-update candidates.
REQ-010 SHALL have port pc, output, 64 bits: current PC to fetch.
REQ-011 SHALL have ports f_en, d_en, e_en, m_en and w_en, output, 1 bit each: stage enables, at most one high.
REQ-012 SHALL have port stat, output, 3 bits: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-013 SHALL have ports busy and halted, output, 1 bit each.
REQ-014 SHALL have port instr_count, output, 32 bits: retired instructions.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD and HALT.
REQ-016 SHALL drive each enable high only in its state: f_en in FETCH, d_en in DECODE, e_en in EXECUTE, m_en in MEMORY, w_en in WRITEBACK; all enables low in IDLE, PCUPD and HALT.
REQ-017 SHALL hold busy high in every state except IDLE and HALT, and SHALL hold halted high only in HALT.
REQ-018 SHALL, in IDLE or HALT with start=1, load pc<=start_pc, set stat<=AOK and enter FETCH; start SHALL be ignored in all other states.
REQ-019 SHALL, at the end of FETCH, check errors in priority order:
- imem_error: stat<=ADR, enter HALT.
- else !instr_valid: stat<=INS, enter HALT.
- else icode==0: stat<=HLT, enter HALT.
- otherwise enter DECODE.
REQ-020 SHALL advance DECODE->EXECUTE->MEMORY in one cycle each.
REQ-021 SHALL, when icode is 4, 5, 8, 9, A or B, remain in MEMORY until mem_ready=1; for all other icodes MEMORY SHALL last exactly one cycle, ignoring mem_ready and dmem_error.
REQ-022 SHALL, when mem_ready=1 and dmem_error=1 in a memory-accessing MEMORY cycle, set stat<=ADR and enter HALT, skipping WRITEBACK and PC update.
REQ-023 SHALL advance WRITEBACK->PCUPD->FETCH in one cycle each.
REQ-024 SHALL, in PCUPD, load pc with:
- valC if icode==8, or if icode==7 and cnd=1;
- valM if icode==9;
- valP otherwise.
REQ-025 SHALL increment instr_count by 1 (wrapping at 2^32) on each PCUPD->FETCH transition only.
REQ-026 SHALL leave pc unchanged when entering HALT, so pc addresses the faulting or halt instruction.
REQ-027 SHALL take minimum latency per instruction of 6 cycles, FETCH entry to next FETCH entry, plus one cycle per memory wait cycle.
REQ-028 SHALL hold stat, pc and instr_count stable in HALT until restarted by start.
REQ-029 SHALL treat icode, cnd and val* as combinational from the datapath and hold no copies of them.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-instruction, asynchronously set state=IDLE, pc=0, stat=AOK(1), instr_count=0, all enables=0, busy=0, halted=0.
REQ-031 SHALL resume normal operation from IDLE on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 Bench SHALL cover: start=1, start_pc=0x20, icode=6 (OPq), valP=0x22 -> f_en,d_en,e_en,m_en,w_en each high one cycle in order; pc=0x22 at the next FETCH; instr_count=1.
REQ-033 Bench SHALL cover: icode=7, cnd=1, valC=0x100, valP=0x29 -> pc=0x100; repeat with cnd=0 -> pc=0x29.
REQ-034 Bench SHALL cover: icode=5 (mrmovq) with mem_ready low for 3 cycles -> m_en high for 4 cycles; the instruction takes 9 cycles; valP is loaded into pc.
REQ-035 Bench SHALL cover: FETCH with instr_valid=0 at pc=0x40 -> stat=4, halted=1, pc=0x40, instr_count unchanged; then start with start_pc=0 -> stat=1 and FETCH.
REQ-036 Bench SHALL cover: icode=A (pushq) with mem_ready=1 and dmem_error=1 -> stat=3, HALT, w_en never asserted; also imem_error=1 and instr_valid=0 together -> stat=3.
REQ-037 Bench SHALL cover: rst_n low during MEMORY -> all outputs return to their reset values immediately without waiting for clk.
